// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the clock divider bank.
// The clamp helper works on 32 bits, so DIV_W must not exceed 32.
package clkdiv_pkg;

  localparam int DIV_W_DEFAULT = 16;
  localparam int MIN_DIV       = 2;

  // Divisors 0 and 1 cannot produce a real period, so raise them to MIN_DIV.
  function automatic logic [31:0] clamp_div(input logic [31:0] val);
    return (val < 32'(MIN_DIV)) ? 32'(MIN_DIV) : val;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: down-counter, active/shadow divisor pair,
// registered divided clock and period-start tick.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wrVal_i,
  output logic             clkOut_o,
  output logic             tick_o,
  output logic             pending_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             clkOut_q, clkOut_d;
  logic             tick_q, tick_d;
  logic [DIV_W-1:0] effDiv;
  logic             running;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      act_q    <= DIV_W'(DEFAULT_DIV);
      shd_q    <= DIV_W'(DEFAULT_DIV);
      pend_q   <= 1'b0;
      clkOut_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      shd_q    <= shd_d;
      pend_q   <= pend_d;
      clkOut_q <= clkOut_d;
      tick_q   <= tick_d;
    end
  end

  // Restart and disable both park the counter at zero, so the next running
  // cycle is a boundary. A write lands after the boundary decision so the
  // boundary always consumes the previous shadow value.
  always_comb begin
    cnt_d    = cnt_q;
    act_d    = act_q;
    shd_d    = shd_q;
    pend_d   = pend_q;
    clkOut_d = 1'b0;
    tick_d   = 1'b0;
    running  = en_i && !restart_i;
    effDiv   = pend_q ? shd_q : act_q;

    if (!running) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      act_d  = effDiv;
      cnt_d  = effDiv - DIV_W'(1);
      pend_d = 1'b0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end

    if (running) begin
      clkOut_d = (cnt_d >= (act_d >> 1));
    end

    if (wr_i) begin
      shd_d  = DIV_W'(clamp_div(32'(wrVal_i)));
      pend_d = 1'b1;
    end
  end

  assign clkOut_o  = clkOut_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent reprogrammable clock dividers sharing one
// system clock, with a global phase-aligning restart.
module clock_divider_bank
  import clkdiv_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int DIV_W       = DIV_W_DEFAULT,
  parameter  int DEFAULT_DIV = 4,
  localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [DIV_W-1:0]  div_val,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  logic [NUM_CH-1:0] chWr;

  // An out-of-range select matches no channel, so the write is dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    assign chWr[i] = div_wr && (div_sel == SEL_W'(i));

    clkdiv_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) uChannel (
      .clk       (clk),
      .reset_n   (reset_n),
      .en_i      (ch_en[i]),
      .restart_i (sync_restart),
      .wr_i      (chWr[i]),
      .wrVal_i   (div_val),
      .clkOut_o  (clk_out[i]),
      .tick_o    (tick[i]),
      .pending_o (pending[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank: expected tick cycles go into
// per-channel queues that a negedge monitor consumes.
module tb_clock_divider_bank;

  localparam int NCH = 5;
  localparam int DW  = 16;
  localparam int SW  = 3;

  logic          clk;
  logic          reset_n;
  logic          div_wr;
  logic [SW-1:0] div_sel;
  logic [DW-1:0] div_val;
  logic [NCH-1:0] ch_en;
  logic          sync_restart;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pending;

  int checks = 0;
  int errors = 0;
  int cyc;
  int expQ[NCH][$];
  logic [NCH-1:0] track = '0;

  clock_divider_bank #(
    .NUM_CH      (NCH),
    .DIV_W       (DW),
    .DEFAULT_DIV (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .div_wr       (div_wr),
    .div_sel      (div_sel),
    .div_val      (div_val),
    .ch_en        (ch_en),
    .sync_restart (sync_restart),
    .clk_out      (clk_out),
    .tick         (tick),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Monitor: every tick on a tracked channel must match the next queued cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (track[ch]) begin
          if (tick[ch]) begin
            checks++;
            if (expQ[ch].size() == 0) begin
              errors++;
              $display("[TB] FAIL tick%0d: unexpected tick at cycle %0d, none required", ch, cyc);
            end else begin
              int e;
              e = expQ[ch].pop_front();
              if (e != cyc) begin
                errors++;
                $display("[TB] FAIL tick%0d: tick at cycle %0d, required at %0d", ch, cyc, e);
              end
            end
          end else if (expQ[ch].size() != 0 && expQ[ch][0] <= cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL tick%0d: no tick at cycle %0d, required at %0d", ch, cyc, expQ[ch][0]);
            void'(expQ[ch].pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic [SW-1:0] sel, input logic [DW-1:0] val);
    div_wr  = wr;
    div_sel = sel;
    div_val = val;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic trackTicks(input int ch, input int first, input int period, input int count);
    for (int j = 0; j < count; j++) expQ[ch].push_back(cyc + first + j * period);
    track[ch] = 1'b1;
  endtask

  task automatic pushTick(input int ch, input int at);
    expQ[ch].push_back(at);
    track[ch] = 1'b1;
  endtask

  task automatic untrack(input int ch);
    while (expQ[ch].size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL tick%0d: required tick at %0d never seen", ch, expQ[ch][0]);
      void'(expQ[ch].pop_front());
    end
    track[ch] = 1'b0;
  endtask

  initial begin
    int t;
    logic [3:0] pat4;
    logic [4:0] pat5;
    logic [5:0] pat6;
    pat4 = 4'b0011;
    pat5 = 5'b00111;
    pat6 = 6'b000111;

    reset_n      = 1'b0;
    sync_restart = 1'b0;
    ch_en        = 5'b00001;
    applyStimulus(1'b0, '0, '0);
    repeat (3) step();
    checkOutput("reset clk_out", 32'(clk_out), 32'h0);
    checkOutput("reset tick", 32'(tick), 32'h0);
    checkOutput("reset pending", 32'(pending), 32'h0);

    // Default divisor 4 on ch0 straight out of reset.
    reset_n = 1'b1;
    trackTicks(0, 1, 4, 3);
    for (int i = 1; i <= 10; i++) begin
      step();
      checkOutput("clk_out0 div4", 32'(clk_out[0]), 32'(pat4[(i - 1) % 4]));
    end
    untrack(0);

    // Reprogram ch1 to 5 mid-period.
    ch_en = 5'b00011;
    t = cyc;
    pushTick(1, t + 1); pushTick(1, t + 5); pushTick(1, t + 10); pushTick(1, t + 15);
    step();
    step();
    applyStimulus(1'b1, 3'd1, 16'd5);
    step();
    applyStimulus(1'b0, '0, '0);
    checkOutput("pending1 held", 32'(pending[1]), 32'h1);
    checkOutput("clk_out1 old", 32'(clk_out[1]), 32'h0);
    step();
    checkOutput("pending1 held", 32'(pending[1]), 32'h1);
    checkOutput("clk_out1 old", 32'(clk_out[1]), 32'h0);
    step();
    checkOutput("pending1 clear", 32'(pending[1]), 32'h0);
    checkOutput("clk_out1 rise", 32'(clk_out[1]), 32'h1);
    t = cyc;
    for (int i = 1; i <= 10; i++) begin
      step();
      checkOutput("clk_out1 div5", 32'(clk_out[1]), 32'(pat5[i % 5]));
    end
    untrack(1);

    // Divisors 0 and 1 on ch2 both clamp to 2.
    applyStimulus(1'b1, 3'd2, 16'd0);
    step();
    applyStimulus(1'b0, '0, '0);
    ch_en = 5'b00111;
    checkOutput("pending2 set", 32'(pending[2]), 32'h1);
    trackTicks(2, 1, 2, 5);
    step();
    checkOutput("pending2 clear", 32'(pending[2]), 32'h0);
    checkOutput("clk_out2 div2", 32'(clk_out[2]), 32'h1);
    step();
    applyStimulus(1'b1, 3'd2, 16'd1);
    checkOutput("clk_out2 div2", 32'(clk_out[2]), 32'h0);
    step();
    applyStimulus(1'b0, '0, '0);
    checkOutput("pending2 set", 32'(pending[2]), 32'h1);
    checkOutput("clk_out2 div2", 32'(clk_out[2]), 32'h1);
    t = cyc;
    for (int i = 1; i <= 6; i++) begin
      step();
      checkOutput("clk_out2 div2", 32'(clk_out[2]), 32'(i % 2 == 0));
      checkOutput("pending2", 32'(pending[2]), 32'(i == 1));
    end
    untrack(2);

    // Program 3,4,6,7, run free, then restart all in phase.
    applyStimulus(1'b1, 3'd0, 16'd3);
    step();
    applyStimulus(1'b1, 3'd1, 16'd4);
    step();
    applyStimulus(1'b1, 3'd2, 16'd6);
    step();
    applyStimulus(1'b1, 3'd3, 16'd7);
    step();
    applyStimulus(1'b0, '0, '0);
    ch_en = 5'b01111;
    repeat (16) step();
    checkOutput("pending settled", 32'(pending), 32'h0);
    sync_restart = 1'b1;
    trackTicks(0, 2, 3, 8);
    trackTicks(1, 2, 4, 6);
    trackTicks(2, 2, 6, 4);
    trackTicks(3, 2, 7, 4);
    step();
    sync_restart = 1'b0;
    checkOutput("restart clk_out", 32'(clk_out[3:0]), 32'h0);
    checkOutput("restart tick", 32'(tick[3:0]), 32'h0);
    step();
    checkOutput("aligned tick", 32'(tick[3:0]), 32'hF);
    checkOutput("aligned clk_out", 32'(clk_out[3:0]), 32'hF);
    step();
    checkOutput("aligned clk_out+1", 32'(clk_out[3:0]), 32'hF);
    step();
    checkOutput("aligned clk_out+2", 32'(clk_out[3:0]), 32'hC);
    repeat (19) step();
    for (int ch = 0; ch < 4; ch++) untrack(ch);

    // Write ch0 in its boundary cycle, then an out-of-range write.
    t = cyc;
    pushTick(0, t + 3); pushTick(0, t + 6); pushTick(0, t + 14); pushTick(0, t + 22);
    trackTicks(1, 3, 4, 5);
    step();
    step();
    applyStimulus(1'b1, 3'd0, 16'd8);
    step();
    applyStimulus(1'b1, 3'd5, 16'd9);
    checkOutput("pending boundary write", 32'(pending), 32'h01);
    step();
    applyStimulus(1'b0, '0, '0);
    checkOutput("pending bad sel", 32'(pending), 32'h01);
    step();
    checkOutput("pending bad sel", 32'(pending), 32'h01);
    step();
    checkOutput("pending0 applied", 32'(pending), 32'h00);
    checkOutput("clk_out0 div8", 32'(clk_out[0]), 32'h1);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i < 8) checkOutput("clk_out0 div8", 32'(clk_out[0]), 32'(i < 4));
    end
    checkOutput("pending idle", 32'(pending), 32'h00);
    untrack(0);
    untrack(1);

    // Disable ch3, reprogram it while parked, re-enable.
    ch_en = 5'b00111;
    track[3] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checkOutput("clk_out3 disabled", 32'(clk_out[3]), 32'h0);
      checkOutput("tick3 disabled", 32'(tick[3]), 32'h0);
      if (i == 5) applyStimulus(1'b1, 3'd3, 16'd6);
      if (i == 6) applyStimulus(1'b0, '0, '0);
      if (i >= 6) checkOutput("pending3 parked", 32'(pending[3]), 32'h1);
    end
    ch_en = 5'b01111;
    trackTicks(3, 1, 6, 3);
    step();
    checkOutput("tick3 first", 32'(tick[3]), 32'h1);
    checkOutput("clk_out3 first", 32'(clk_out[3]), 32'h1);
    checkOutput("pending3 applied", 32'(pending[3]), 32'h0);
    for (int i = 1; i <= 12; i++) begin
      step();
      checkOutput("clk_out3 div6", 32'(clk_out[3]), 32'(pat6[i % 6]));
    end
    untrack(3);

    // Asynchronous reset in the middle of a period.
    applyStimulus(1'b1, 3'd2, 16'd9);
    step();
    applyStimulus(1'b0, '0, '0);
    checkOutput("pending2 before reset", 32'(pending[2]), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset clk_out", 32'(clk_out), 32'h0);
    checkOutput("async reset tick", 32'(tick), 32'h0);
    checkOutput("async reset pending", 32'(pending), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
Parametrised successor to the single fixed-ratio divider. It provides NUM_CH independent integer clock-enable/divided-clock generators from one system clock. Each channel has:
- a divisor that software can reprogram at run time, applied glitch-free at the period boundary;
- an enable input;
- a one-cycle tick at each period start.

A global restart aligns all channel phases. The block sits between the board oscillator and the peripheral blocks that need slow strobes (UART baud, LED PWM, sampling).

Parameters:
NUM_CH, 4, number of divider channels (1..16)
DIV_W, 16, divisor and counter width in bits
DEFAULT_DIV, 4, divisor loaded into every channel at reset (2..2^DIV_W-1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
div_wr  input  1  divisor write strobe, one cycle
div_sel  input  $clog2(NUM_CH) (min 1)  channel index for the write
div_val  input  DIV_W  new divisor value
ch_en  input  NUM_CH  per-channel run enable
sync_restart  input  1  restart all channels in phase
clk_out  output  NUM_CH  divided clock per channel (registered)
tick  output  NUM_CH  one-cycle pulse at start of each period (registered)
pending  output  NUM_CH  shadow divisor written but not yet applied

Behaviour:
- Per-channel state:
  - cnt: DIV_W bits, down-counter
  - act: DIV_W bits, active divisor
  - shd: DIV_W bits, shadow divisor
  - pend: 1 bit
- Reset (async, reset_n=0):
  - cnt=0; act=shd=DEFAULT_DIV; pend=0
  - clk_out=0, tick=0, pending=0 for all channels.
- Write:
  - div_wr=1 and div_sel<NUM_CH: shd[sel] <= clamp(div_val) and pend[sel] <= 1.
  - clamp: values 0 and 1 become 2.
  - div_sel>=NUM_CH: the write is ignored; no state changes.
- Boundary: channel enabled and cnt==0 in the current cycle.
  - eff = pend ? shd : act
  - act <= eff; cnt <= eff-1; pend <= 0; tick <= 1.
- Non-boundary, enabled: cnt <= cnt-1; tick <= 0.
- clk_out registered: clk_out <= (cnt_next >= (act_next >> 1)).
  - For divisor N: high for ceil(N/2) cycles, low for floor(N/2) cycles.
  - Rising edge of clk_out coincides with tick.
- Write in the same cycle as that channel's boundary:
  - The boundary uses the old shd/pend.
  - The new value is captured and pend stays 1, so it applies at the following boundary.
  - A second write before the boundary overwrites shd; last write wins.
- Disabled channel (ch_en=0):
  - cnt <= 0; clk_out <= 0; tick <= 0.
  - Writes are still captured and act is unchanged.
  - The first enabled cycle has cnt==0, so it is a boundary: tick and clk_out rise on the next edge.
- sync_restart=1:
  - All channels: cnt <= 0, clk_out <= 0, tick <= 0.
  - Overrides counting and boundary, so pend is not consumed that cycle.
  - Writes are still captured.
  - The next cycle is a simultaneous boundary for every enabled channel.
- Counter never wraps: the maximum load is 2^DIV_W-2.
- Latency: write to applied divisor = next boundary of that channel; period = act cycles.

Decomposition:
- Shared package clkdiv_pkg holds:
  - DIV_W default
  - MIN_DIV=2 constant
  - clamp_div function
- Sub-module clkdiv_channel holds one channel's cnt/act/shd/pend/out/tick logic.
  - Inputs: en, restart, wr, wr_val.
- The top level decodes div_sel into per-channel wr and generates NUM_CH instances.

Test Plan:
1. Reset with DEFAULT_DIV=4, ch_en=1 on ch0; release reset_n.
   - Required: tick0 pulses every 4 cycles.
   - Required: clk_out0 pattern 1,1,0,0 repeating, with its first rise coincident with the first tick.
2. Write div_val=5 to ch1 mid-period.
   - Required: pending1=1 until the next boundary.
   - Required: that period stays 4 cycles, then period 5 with pattern 1,1,1,0,0.
   - Required: pending1 clears at that boundary.
3. Write div_val=0 and div_val=1 to ch2.
   - Required: both are applied as divisor 2; clk_out2 toggles every cycle and tick2 is asserted every other cycle.
4. Channels 0..3 at divisors 3,4,6,7, free-running; pulse sync_restart.
   - Required: all clk_out=0 one cycle.
   - Required: all tick assert in the same cycle after that.
   - Required: subsequent periods are 3,4,6,7.
5. Write ch0 div_val=8 in the exact boundary cycle.
   - Required: the next period is the old divisor and pending0 stays 1.
   - Required: the period after that is 8.
   - Also: write div_sel=NUM_CH with any value; required: no channel changes.
6. Deassert ch_en[3] for 10 cycles, write 6, reassert.
   - Required: clk_out3=0 and tick3=0 while disabled.
   - Required: the first tick follows the enabling edge by one cycle, with period 6.
   - Also: assert reset_n low mid-period; required: all outputs are 0 asynchronously.
